alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit single-cycle ALU datapath: operand width and pipeline depth are generic.
- Adds valid/ready handshaking on both the input and output sides, an illegal-opcode error flag, a zero flag and a saturating completed-operation counter.
- Sits between the stimulus driver and the result monitor/scoreboard path.
- Serves as the reusable arithmetic core for wider datapaths.

Parameters:
- WIDTH, 4, operand width in bits (>=2).
- PIPE_STAGES, 2, register stages from input acceptance to result (1..4).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- i  input  4  opcode.
- in_valid  input  1  operands/opcode valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- s  output  WIDTH+2  result.
- zero  output  1  s == 0.
- err  output  1  opcode was illegal.
- out_valid  output  1  s/zero/err valid.
- out_ready  input  1  consumer takes result this cycle.
- op_count  output  CNT_W  completed-transfer counter, saturating.

Behaviour:
- Reset: a synchronous reset samples rst high at a clk edge.
  - All stage valid bits clear; out_valid=0, s=0, zero=0, err=0, op_count=0.
  - in_ready is combinational and reads 1 from the cycle after the reset edge.
  - Reset mid-operation discards all in-flight ops; none are emitted.
- Advance: adv = !out_valid || out_ready.
  - in_ready = adv.
  - An input transfer occurs when in_valid && in_ready.
  - When adv=1, every stage loads from its predecessor. Stage 0 loads {result, valid=in_valid}.
  - When adv=0, all stages hold.
  - Bubbles are not collapsed.
- Latency: a transfer accepted at edge N presents out_valid=1 after edge N+PIPE_STAGES-1, provided no stall occurs. Throughput is 1 op/cycle when out_ready=1.
- Stability: while out_valid=1 && out_ready=0, s/zero/err remain stable and in_ready=0.
- Result computation: combinational at stage 0, then carried through the stages. Results are zero-extended to WIDTH+2 unless stated otherwise.
  - 0 ADD: a+b in WIDTH+1 bits; bit WIDTH is carry.
  - 1 SUB: a-b mod 2^(WIDTH+1); bit WIDTH = borrow (a<b).
  - 2 AND, 3 OR, 4 XOR: bitwise on WIDTH bits.
  - 5 NOT: ~a on WIDTH bits.
  - 6 SHL: {a,1'b0} in WIDTH+1 bits.
  - 7 SHR: a>>1.
  - 8 INC: a+1 with carry at bit WIDTH.
  - 9 DEC: a-1 mod 2^(WIDTH+1); borrow at bit WIDTH when a==0.
  - 10 CMP: s[2:0] = {a>b, a==b, a<b} unsigned; upper bits 0.
  - 11 PASS: s = a.
  - 12-15 illegal: s=0, err=1.
- Flags:
  - err=0 for legal opcodes.
  - zero = (s==0); zero=1 also accompanies illegal ops.
- op_count:
  - Increments by 1 on each output transfer (out_valid && out_ready), including err results.
  - Saturates at 2^CNT_W-1.
- Simultaneous events: if rst is high in the same cycle as an input or output transfer, reset wins. No transfer is counted and none is emitted.

Test Plan (WIDTH=4, PIPE_STAGES=2, out_ready=1 unless stated):
- ADD a=4'hF, b=4'h1, accepted at edge N -> out_valid after edge N+1 with s=6'h10, zero=0, err=0; op_count becomes 1 at the next edge.
- SUB a=3, b=5 -> s=6'h1E (borrow bit 4 set). DEC a=0 -> s=6'h1F. INC a=4'hF -> s=6'h10.
- CMP a=7, b=7 -> s=6'h02. CMP a=2, b=9 -> s=6'h01. Opcode 13 -> s=0, err=1, zero=1.
- Back-to-back stream of 4 ADDs, with out_ready low for 3 cycles once the first result is valid:
  - in_ready=0 during the stall and s holds its value.
  - All 4 results are delivered in order with none lost or duplicated; op_count=4.
- Reset pulse with 2 ops in flight -> out_valid=0 and op_count=0 after the reset edge; no stale result appears afterwards; a new op has normal latency.
- CNT_W=3, 9 output transfers -> op_count=7 and stays at 7.

Source files
------------

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// alu_pipe : pipelined ALU with valid/ready handshake, flags and op counter
// Rev 1.0
// ============================================================================
module alu_pipe #(
   parameter int WIDTH       = 4,
   parameter int PIPE_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [3:0]         i,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH+1:0]   s,
   output logic               zero,
   output logic               err,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CNT_W-1:0]   op_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);

   logic [WIDTH:0]   ax;
   logic [WIDTH:0]   bx;
   logic [WIDTH+1:0] res;
   logic             res_err;
   logic             adv;

   logic [PIPE_STAGES-1:0] vld;
   logic [PIPE_STAGES-1:0] zero_q;
   logic [PIPE_STAGES-1:0] err_q;
   logic [WIDTH+1:0]       s_q [PIPE_STAGES];

   assign ax = {1'b0, a};
   assign bx = {1'b0, b};

   always_comb begin
      res     = '0;
      res_err = 1'b0;
      case (i)
         4'd0:    res = {1'b0, ax + bx};
         4'd1:    res = {1'b0, ax - bx};
         4'd2:    res = {2'b00, a & b};
         4'd3:    res = {2'b00, a | b};
         4'd4:    res = {2'b00, a ^ b};
         4'd5:    res = {2'b00, ~a};
         4'd6:    res = {1'b0, a, 1'b0};
         4'd7:    res = {2'b00, a >> 1};
         4'd8:    res = {1'b0, ax + ONE_X};
         4'd9:    res = {1'b0, ax - ONE_X};
         4'd10:   res[2:0] = {a > b, a == b, a < b};
         4'd11:   res = {2'b00, a};
         default: res_err = 1'b1;
      endcase
   end

   // A full output that is not being drained stalls the entire pipe.
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld[PIPE_STAGES-1];
   assign s         = s_q[PIPE_STAGES-1];
   assign zero      = zero_q[PIPE_STAGES-1];
   assign err       = err_q[PIPE_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld      <= '0;
         zero_q   <= '0;
         err_q    <= '0;
         op_count <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) begin
            s_q[k] <= '0;
         end
      end else begin
         if (adv) begin
            vld[0]    <= in_valid;
            s_q[0]    <= res;
            zero_q[0] <= (res == '0);
            err_q[0]  <= res_err;
            for (int k = 1; k < PIPE_STAGES; k++) begin
               vld[k]    <= vld[k-1];
               s_q[k]    <= s_q[k-1];
               zero_q[k] <= zero_q[k-1];
               err_q[k]  <= err_q[k-1];
            end
         end
         if (out_valid && out_ready && (op_count != CNT_MAX)) begin
            op_count <= op_count + CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// tb_alu_pipe : directed + randomized bench with a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_alu_pipe;

   localparam int W = 4;

   typedef struct packed {
      logic [W+1:0] s;
      logic         e;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   i = '0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;

   wire          in_ready, out_valid, zero, err;
   wire [W+1:0]  s;
   wire [15:0]   op_count;
   wire          in_ready_sat, out_valid_sat, zero_sat, err_sat;
   wire [W+1:0]  s_sat;
   wire [2:0]    cnt_sat;

   int   compared   = 0;
   int   mismatched = 0;
   exp_t q[$];
   exp_t cur;
   int   m_cnt = 0;
   int   m_sat = 0;
   int   base;
   bit   acc;
   bit   prev_stall = 1'b0;
   logic [W+1:0] prev_s;
   logic prev_z, prev_e;

   alu_pipe #(.WIDTH(W), .PIPE_STAGES(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .i(i),
      .in_valid(in_valid), .in_ready(in_ready),
      .s(s), .zero(zero), .err(err),
      .out_valid(out_valid), .out_ready(out_ready), .op_count(op_count)
   );

   alu_pipe #(.WIDTH(W), .PIPE_STAGES(2), .CNT_W(3)) dut_sat (
      .clk(clk), .rst(rst), .a(a), .b(b), .i(i),
      .in_valid(in_valid), .in_ready(in_ready_sat),
      .s(s_sat), .zero(zero_sat), .err(err_sat),
      .out_valid(out_valid_sat), .out_ready(out_ready), .op_count(cnt_sat)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Opcode semantics computed with plain integer arithmetic.
   function automatic exp_t model(input int x, input int y, input int op);
      int   m;
      int   r;
      exp_t e;
      m = 1 << (W + 1);
      r = 0;
      case (op)
         0:  r = x + y;
         1:  r = (x - y + m) % m;
         2:  r = x & y;
         3:  r = x | y;
         4:  r = x ^ y;
         5:  r = (~x) & ((1 << W) - 1);
         6:  r = x * 2;
         7:  r = x / 2;
         8:  r = x + 1;
         9:  r = (x - 1 + m) % m;
         10: r = (x > y) ? 4 : ((x == y) ? 2 : 1);
         11: r = x;
         default: r = 0;
      endcase
      e.s = r[W+1:0];
      e.e = (op >= 12);
      return e;
   endfunction

   task automatic cycle();
      exp_t e;
      @(negedge clk);
      check("op_count", op_count, m_cnt);
      check("sat_count", cnt_sat, m_sat);
      acc = 1'b0;
      if (prev_stall) begin
         check("hold_s", s, prev_s);
         check("hold_flags", {out_valid, zero, err}, {1'b1, prev_z, prev_e});
      end
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      prev_stall = !rst && out_valid && !out_ready;
      prev_s = s; prev_z = zero; prev_e = err;
      if (rst) begin
         q.delete();
         m_cnt = 0;
         m_sat = 0;
      end else begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("spurious_out_valid", out_valid, 0);
            end else begin
               e = q.pop_front();
               check("s", s, e.s);
               check("err", err, e.e);
               check("zero", zero, (e.s == 0));
            end
            if (m_cnt < 65535) m_cnt++;
            if (m_sat < 7) m_sat++;
         end
         if (in_valid && in_ready) begin
            q.push_back(cur);
            acc = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int x, input int y, input int op, input int es, input int ee);
      a = x[W-1:0]; b = y[W-1:0]; i = op[3:0];
      in_valid = 1'b1;
      cur.s = es[W+1:0];
      cur.e = ee[0];
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (acc) return;
      end
      check("accept_timeout", acc, 1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) cycle();
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (2) cycle();
      check("rst_out_valid", out_valid, 0);
      check("rst_s", s, 0);
      check("rst_zero", zero, 0);
      check("rst_err", err, 0);
      check("rst_op_count", op_count, 0);
      check("in_ready_after_rst", in_ready, 1);
      rst = 1'b0;

      // Latency of a single ADD with carry
      send(15, 1, 0, 'h10, 0);
      check("lat_edge_n_valid", out_valid, 0);
      in_valid = 1'b0;
      cycle();
      check("lat_edge_n1_valid", out_valid, 1);
      check("add_carry_s", s, 'h10);
      cycle();
      check("count_after_add", op_count, 1);

      // Directed opcodes and boundaries
      send(3, 5, 1, 'h1E, 0);
      send(0, 0, 9, 'h1F, 0);
      send(15, 0, 8, 'h10, 0);
      send(7, 7, 10, 'h02, 0);
      send(2, 9, 10, 'h01, 0);
      send(5, 6, 13, 0, 1);
      send(12, 10, 2, 'h08, 0);
      send(12, 10, 4, 'h06, 0);
      send(9, 0, 5, 'h06, 0);
      send(9, 0, 6, 'h12, 0);
      idle(4);
      check("drain_empty", q.size(), 0);

      // Reset with two ops in flight
      send(1, 2, 0, 3, 0);
      send(4, 4, 0, 8, 0);
      in_valid = 1'b0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_op_count", op_count, 0);
      idle(5);
      send(9, 3, 2, 'h01, 0);
      check("post_rst_lat_n", out_valid, 0);
      in_valid = 1'b0;
      cycle();
      check("post_rst_lat_n1", out_valid, 1);
      check("post_rst_s", s, 'h01);
      idle(2);

      // Back-to-back stream with a 3-cycle output stall
      base = m_cnt;
      send(1, 1, 0, 'h02, 0);
      send(2, 3, 0, 'h05, 0);
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (3) cycle();
      out_ready = 1'b1;
      send(8, 8, 0, 'h10, 0);
      send(15, 15, 0, 'h1E, 0);
      idle(4);
      check("stream_count", op_count, base + 4);
      check("stream_empty", q.size(), 0);

      // Randomized traffic, including illegal opcodes and backpressure
      for (int n = 0; n < 400; n++) begin
         int x, y, op;
         x = $urandom_range(0, 15);
         y = $urandom_range(0, 15);
         op = $urandom_range(0, 15);
         a = x[W-1:0]; b = y[W-1:0]; i = op[3:0];
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         cur = model(x, y, op);
         cycle();
      end
      out_ready = 1'b1;
      idle(6);
      check("random_empty", q.size(), 0);
      check("sat_final", cnt_sat, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
